// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit slice.
//   - fetch_state_e : fetch FSM state encoding (IDLE, RUN, HALT, FAULT)
//   - IFU_ADDR_W / IFU_DATA_W : default address / instruction widths
//   - NOP_INSTR : instruction presented on out_instr while the FIFO is empty
package instruction_fetch_unit_pkg;

  localparam int unsigned IFU_ADDR_W = 32;
  localparam int unsigned IFU_DATA_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit and its neighbours.
//   Memory side : addra (word address), wea / dina (write port, unused), douta (read data)
//   Decode side : out_instr / out_pc / out_valid from fetch, out_ready from decode
// Modports:
//   master : the fetch unit (drives address and the decode handshake payload)
//   slave  : memory + decode (drive douta and out_ready)
interface instruction_fetch_unit_if
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = IFU_ADDR_W,
  parameter int unsigned DATA_W = IFU_DATA_W
);

  logic [ADDR_W-1:0] addra;
  logic              wea;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;

  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output addra, wea, dina,
    input  douta,
    output out_instr, out_pc, out_valid,
    input  out_ready
  );

  modport slave (
    input  addra, wea, dina,
    output douta,
    input  out_instr, out_pc, out_valid,
    output out_ready
  );

endinterface

// File: rtl/instruction_fetch_unit_fifo.sv
// fetch_skid_fifo: 2-entry skid buffer holding {pc, instr} fetch results.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : enqueue one entry
//   pop        : dequeue head (ignored when empty)
//   flush      : discard all entries; wins over push and pop
//   rdata      : head entry, valid when valid=1
//   count      : occupancy 0..2
// Push and pop in the same cycle are allowed, including when full.
module fetch_skid_fifo #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (cnt != 2'd0);
  assign do_push = push & ((cnt != 2'd2) | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end

  // Storage needs no reset: contents are qualified by cnt.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign valid = (cnt != 2'd0);
  assign count = cnt;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, issues word addresses to an
// instruction memory whose douta is valid the cycle after addra changes,
// and hands {instr, pc} to decode through a 2-entry skid FIFO.
// Ports:
//   clka, rst_n    : clock, asynchronous active-low reset
//   bus (master)   : addra/wea/dina/douta memory port, out_* decode handshake
//   branch_valid   : 1-cycle redirect request, target in branch_target
//   halt_req       : level; stop issuing while high
//   halted         : in HALT with no read outstanding
//   fetch_fault    : sticky, set by an out-of-range branch target
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IFU_ADDR_W,
  parameter int unsigned       DATA_W   = IFU_DATA_W,
  parameter int unsigned       MEM_SIZE = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clka,
  input  logic                      rst_n,
  instruction_fetch_unit_if.master  bus,
  input  logic                      branch_valid,
  input  logic [ADDR_W-1:0]         branch_target,
  input  logic                      halt_req,
  output logic                      halted,
  output logic                      fetch_fault
);

  localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W+1)'(MEM_SIZE);
  localparam logic [ADDR_W-1:0] PC_MASK   = ADDR_W'(MEM_SIZE - 1);

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] p);
    return (p + ADDR_W'(1)) & PC_MASK;
  endfunction

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [ADDR_W-1:0] addra_q, addra_next;
  logic              inflight, inflight_next;
  logic              tag, tag_next;
  logic              epoch, epoch_next;

  logic                     flush;
  logic                     push;
  logic                     pop;
  logic                     fifo_valid;
  logic [1:0]               fifo_count;
  logic [ADDR_W+DATA_W-1:0] fifo_rdata;

  logic       target_ok;
  logic       fault_hit;
  logic       redirect;
  logic [2:0] load;
  logic       room;

  assign target_ok = ({1'b0, branch_target} < MEM_LIMIT);
  assign fault_hit = branch_valid & ~target_ok & (state != ST_FAULT);
  assign redirect  = branch_valid &  target_ok & (state != ST_FAULT);

  assign bus.out_valid = fifo_valid & ~branch_valid & (state != ST_FAULT);
  assign pop           = bus.out_valid & bus.out_ready;

  // Issue only if the read can still land next cycle without overflowing,
  // counting the head leaving this cycle: occupancy + inflight - pop < 2.
  assign load = {1'b0, fifo_count} + {2'b00, inflight};
  assign room = (load < (3'd2 + {2'b00, pop}));

  // addra still holds the issued address when its data returns.
  assign push = inflight & (tag == epoch);

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    addra_next    = addra_q;
    inflight_next = 1'b0;
    tag_next      = tag;
    epoch_next    = epoch;
    flush         = 1'b0;

    unique case (state)
      ST_IDLE:  state_next = ST_RUN;
      ST_RUN:   if (halt_req)  state_next = ST_HALT;
      ST_HALT:  if (!halt_req) state_next = ST_RUN;
      ST_FAULT: state_next = ST_FAULT;
    endcase

    if (fault_hit) begin
      state_next = ST_FAULT;
      flush      = 1'b1;
    end else if (redirect) begin
      // The redirect cycle itself issues from the target so the first
      // redirected instruction is visible two cycles after branch_valid.
      flush      = 1'b1;
      epoch_next = ~epoch;
      if (state == ST_RUN && !halt_req) begin
        addra_next    = branch_target;
        pc_next       = pc_inc(branch_target);
        inflight_next = 1'b1;
        tag_next      = ~epoch;
      end else begin
        pc_next = branch_target;
      end
    end else if (state == ST_RUN && !halt_req && room) begin
      addra_next    = pc;
      pc_next       = pc_inc(pc);
      inflight_next = 1'b1;
      tag_next      = epoch;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      addra_q  <= RESET_PC;
      inflight <= 1'b0;
      tag      <= 1'b0;
      epoch    <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      addra_q  <= addra_next;
      inflight <= inflight_next;
      tag      <= tag_next;
      epoch    <= epoch_next;
    end
  end

  fetch_skid_fifo #(
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clka),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({addra_q, bus.douta}),
    .pop   (pop),
    .flush (flush),
    .rdata (fifo_rdata),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign bus.addra     = addra_q;
  assign bus.wea       = 1'b0;
  assign bus.dina      = '0;
  assign bus.out_pc    = fifo_rdata[ADDR_W+DATA_W-1:DATA_W];
  assign bus.out_instr = fifo_valid ? fifo_rdata[DATA_W-1:0] : DATA_W'(NOP_INSTR);

  assign halted      = (state == ST_HALT) & ~inflight;
  assign fetch_fault = (state == ST_FAULT);

endmodule
